// File: rtl/bp_me_mem_cmd_arbiter.sv
// Round-robin arbiter sharing one BedRock memory port between two requesters.
// Commands go out through a one-entry buffer; responses return in command order.
module bp_me_mem_cmd_arbiter #(
  parameter int msg_width_p   = 256,
  parameter int outstanding_p = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [2*msg_width_p-1:0] cmd_i,
  input  logic [1:0]               cmd_v_i,
  output logic [1:0]               cmd_ready_o,
  output logic [msg_width_p-1:0]   resp_o,
  output logic [1:0]               resp_v_o,
  input  logic [1:0]               resp_yumi_i,
  output logic [msg_width_p-1:0]   mem_cmd_o,
  output logic                     mem_cmd_v_o,
  input  logic                     mem_cmd_ready_i,
  input  logic [msg_width_p-1:0]   mem_resp_i,
  input  logic                     mem_resp_v_i,
  output logic                     mem_resp_yumi_o,
  output logic                     error_o
);

  localparam int ptr_w = (outstanding_p > 1) ? $clog2(outstanding_p) : 1;
  localparam int cnt_w = $clog2(outstanding_p + 1);

  logic [msg_width_p-1:0] obuf_r;
  logic                   obuf_v_r;
  logic                   fifo_r [outstanding_p];
  logic [ptr_w-1:0]       wr_ptr_r, rd_ptr_r;
  logic [cnt_w-1:0]       count_r;
  logic                   last_r;
  logic                   error_r;

  logic       empty, full, head, obuf_load_ok;
  logic [1:0] grant, accept;
  logic       push, push_id, pop, protocol_err;

  function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
    return (p == ptr_w'(outstanding_p - 1)) ? '0 : p + ptr_w'(1);
  endfunction

  assign empty        = (count_r == '0);
  assign full         = (count_r == cnt_w'(outstanding_p));
  assign head         = fifo_r[rd_ptr_r];
  assign obuf_load_ok = ~obuf_v_r | mem_cmd_ready_i;

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    grant    = 2'b00;
    grant[0] = cmd_v_i[0] & (~cmd_v_i[1] | last_r);
    grant[1] = cmd_v_i[1] & (~cmd_v_i[0] | ~last_r);
  end

  // Ready is held low while reset is asserted even though the state is already cleared.
  assign cmd_ready_o = grant & {2{obuf_load_ok & ~full & reset_i}};
  assign accept      = cmd_v_i & cmd_ready_o;
  assign push        = |accept;
  assign push_id     = accept[1];

  assign resp_o          = mem_resp_i;
  assign mem_resp_yumi_o = resp_yumi_i[head] & ~empty;
  assign pop             = mem_resp_v_i & mem_resp_yumi_o;

  always_comb begin
    resp_v_o       = 2'b00;
    resp_v_o[head] = mem_resp_v_i & ~empty;
  end

  assign protocol_err = (mem_resp_v_i & empty) | (|(resp_yumi_i & ~resp_v_o));

  assign mem_cmd_o   = obuf_r;
  assign mem_cmd_v_o = obuf_v_r;
  assign error_o     = error_r;

  // NOTE: payload storage carries no reset; its valid/count state alone defines what is live.
  always_ff @(posedge clk_i) begin
    if (push) begin
      obuf_r           <= push_id ? cmd_i[2*msg_width_p-1:msg_width_p] : cmd_i[msg_width_p-1:0];
      fifo_r[wr_ptr_r] <= push_id;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      obuf_v_r <= 1'b0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      last_r   <= 1'b1;
      error_r  <= 1'b0;
    end else begin
      if (push)
        obuf_v_r <= 1'b1;
      else if (mem_cmd_ready_i)
        obuf_v_r <= 1'b0;

      if (push) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
        last_r   <= push_id;
      end
      if (pop)
        rd_ptr_r <= ptr_inc(rd_ptr_r);

      case ({push, pop})
        2'b10:   count_r <= count_r + cnt_w'(1);
        2'b01:   count_r <= count_r - cnt_w'(1);
        default: count_r <= count_r;
      endcase

      error_r <= error_r | protocol_err;
    end
  end

endmodule

// File: tb/tb_bp_me_mem_cmd_arbiter.sv
// Scoreboard bench for bp_me_mem_cmd_arbiter: predicted commands and response
// routing are queued as stimulus is driven and popped as the DUT produces them.
module tb_bp_me_mem_cmd_arbiter;

  localparam int W   = 32;
  localparam int OUT = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [2*W-1:0] cmd;
  logic [1:0]     cmd_v, cmd_ready, resp_v, resp_yumi;
  logic [W-1:0]   resp, mem_cmd, mem_resp;
  logic           mem_cmd_v, mem_cmd_ready, mem_resp_v, mem_resp_yumi, error;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] req0_q[$], req1_q[$];
  logic [W-1:0] exp_cmd_q[$];
  logic [W-1:0] mem_pend_q[$];
  logic [1:0]   exp_resp_q[$];

  always #5 clk = ~clk;

  bp_me_mem_cmd_arbiter #(.msg_width_p(W), .outstanding_p(OUT)) dut (
    .clk_i(clk), .reset_i(rst_n),
    .cmd_i(cmd), .cmd_v_i(cmd_v), .cmd_ready_o(cmd_ready),
    .resp_o(resp), .resp_v_o(resp_v), .resp_yumi_i(resp_yumi),
    .mem_cmd_o(mem_cmd), .mem_cmd_v_o(mem_cmd_v), .mem_cmd_ready_i(mem_cmd_ready),
    .mem_resp_i(mem_resp), .mem_resp_v_i(mem_resp_v), .mem_resp_yumi_o(mem_resp_yumi),
    .error_o(error)
  );

  function automatic logic [W-1:0] mk(input logic r, input int k);
    return {8'hA5, 8'(k), 15'h0, r};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    cmd = '0; cmd_v = 2'b00; resp_yumi = 2'b00;
    mem_cmd_ready = 1'b1; mem_resp = '0; mem_resp_v = 1'b0;
    req0_q.delete(); req1_q.delete(); exp_cmd_q.delete();
    mem_pend_q.delete(); exp_resp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  // One cycle of command traffic; the memory side accepts whatever it is offered.
  task automatic issue_cycle(input logic [1:0] exp_ready, input int exp_mcv);
    logic [1:0]   hs;
    logic [W-1:0] p0, p1, exp_c;
    p0 = (req0_q.size() > 0) ? req0_q[0] : '0;
    p1 = (req1_q.size() > 0) ? req1_q[0] : '0;
    cmd   = {p1, p0};
    cmd_v = {req1_q.size() > 0, req0_q.size() > 0};
    #1;
    if (exp_mcv >= 0) begin
      n_cmp++;
      if (mem_cmd_v !== exp_mcv[0]) begin
        n_bad++;
        $display("FAIL mem_cmd_v: got %b expected %b at %0t", mem_cmd_v, exp_mcv[0], $time);
      end
    end
    n_cmp++;
    if (cmd_ready !== exp_ready) begin
      n_bad++;
      $display("FAIL cmd_ready: got %b expected %b at %0t", cmd_ready, exp_ready, $time);
    end
    hs = cmd_v & cmd_ready;
    if (mem_cmd_v && mem_cmd_ready) begin
      n_cmp++;
      exp_c = (exp_cmd_q.size() > 0) ? exp_cmd_q.pop_front() : '0;
      if (mem_cmd !== exp_c) begin
        n_bad++;
        $display("FAIL mem_cmd: got %h expected %h at %0t", mem_cmd, exp_c, $time);
      end
      mem_pend_q.push_back(mem_cmd);
    end
    step();
    if (hs[0]) begin
      exp_cmd_q.push_back(p0);
      exp_resp_q.push_back(p0[0] ? 2'b10 : 2'b01);
      void'(req0_q.pop_front());
    end
    if (hs[1]) begin
      exp_cmd_q.push_back(p1);
      exp_resp_q.push_back(p1[0] ? 2'b10 : 2'b01);
      void'(req1_q.pop_front());
    end
  endtask

  task automatic drain_resps(input int n);
    logic [W-1:0] d;
    logic [1:0]   e;
    cmd_v = 2'b00;
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      if (mem_pend_q.size() == 0 || exp_resp_q.size() == 0) begin
        n_bad++;
        $display("FAIL resp_queue: got %0d pending expected %0d", mem_pend_q.size(), n - i);
        break;
      end
      d = mem_pend_q.pop_front();
      e = exp_resp_q.pop_front();
      mem_resp = ~d; mem_resp_v = 1'b1; resp_yumi = e;
      #1;
      if (resp_v !== e) begin
        n_bad++;
        $display("FAIL resp_v: got %b expected %b at %0t", resp_v, e, $time);
      end
      n_cmp++;
      if (mem_resp_yumi !== 1'b1 || resp !== ~d) begin
        n_bad++;
        $display("FAIL resp_data: got %b/%h expected 1/%h", mem_resp_yumi, resp, ~d);
      end
      step();
    end
    mem_resp_v = 1'b0; resp_yumi = 2'b00;
  endtask

  task automatic check_no_error(input string tag);
    n_cmp++;
    if (error !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_error: got %b expected 0", tag, error);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cmd = '0; cmd_v = 2'b11; resp_yumi = 2'b00;
    mem_cmd_ready = 1'b1; mem_resp = '0; mem_resp_v = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({mem_cmd_v, resp_v, mem_resp_yumi, cmd_ready, error} !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b expected 0000000",
               {mem_cmd_v, resp_v, mem_resp_yumi, cmd_ready, error});
    end
  endtask

  task automatic test_single();
    apply_reset();
    for (int k = 0; k < 3; k++) req0_q.push_back(mk(1'b0, k));
    issue_cycle(2'b01, 0);
    issue_cycle(2'b01, 1);
    issue_cycle(2'b01, 1);
    issue_cycle(2'b00, 1);
    issue_cycle(2'b00, 0);
    drain_resps(3);
    check_no_error("single");
  endtask

  task automatic test_fairness();
    apply_reset();
    for (int k = 0; k < 2; k++) begin
      req0_q.push_back(mk(1'b0, 16 + k));
      req1_q.push_back(mk(1'b1, 32 + k));
    end
    issue_cycle(2'b01, 0);
    issue_cycle(2'b10, 1);
    issue_cycle(2'b01, 1);
    issue_cycle(2'b10, 1);
    issue_cycle(2'b00, 1);
    drain_resps(4);
    check_no_error("fair");
  endtask

  task automatic test_full();
    logic [W-1:0] d;
    apply_reset();
    for (int k = 0; k < 5; k++) req0_q.push_back(mk(1'b0, 48 + k));
    for (int k = 0; k < OUT; k++) issue_cycle(2'b01, -1);
    issue_cycle(2'b00, 1);
    issue_cycle(2'b00, 0);
    // Pop in the same cycle does not unblock the push.
    d = (mem_pend_q.size() > 0) ? mem_pend_q.pop_front() : '0;
    void'(exp_resp_q.pop_front());
    mem_resp = ~d; mem_resp_v = 1'b1; resp_yumi = 2'b01;
    #1;
    n_cmp++;
    if (resp_v !== 2'b01 || mem_resp_yumi !== 1'b1) begin
      n_bad++;
      $display("FAIL full_pop: got %b/%b expected 01/1", resp_v, mem_resp_yumi);
    end
    issue_cycle(2'b00, 0);
    mem_resp_v = 1'b0; resp_yumi = 2'b00;
    issue_cycle(2'b01, 0);
    issue_cycle(2'b00, 1);
    drain_resps(4);
    check_no_error("full");
  endtask

  task automatic test_backpressure();
    logic [W-1:0] p0;
    apply_reset();
    p0 = mk(1'b0, 64);
    req0_q.push_back(p0);
    req0_q.push_back(mk(1'b0, 65));
    mem_cmd_ready = 1'b0;
    issue_cycle(2'b01, 0);
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (mem_cmd !== p0) begin
        n_bad++;
        $display("FAIL bp_hold: got %h expected %h cycle %0d", mem_cmd, p0, c);
      end
      issue_cycle(2'b00, 1);
    end
    mem_cmd_ready = 1'b1;
    issue_cycle(2'b01, 1);
    issue_cycle(2'b00, 1);
    issue_cycle(2'b00, 0);
    drain_resps(2);
    check_no_error("bp");
  endtask

  task automatic test_protocol_error();
    apply_reset();
    mem_resp = 32'hDEAD_BEEF; mem_resp_v = 1'b1; resp_yumi = 2'b00;
    #1;
    n_cmp++;
    if (mem_resp_yumi !== 1'b0 || resp_v !== 2'b00 || error !== 1'b0) begin
      n_bad++;
      $display("FAIL err_empty: got %b/%b/%b expected 0/00/0", mem_resp_yumi, resp_v, error);
    end
    step();
    mem_resp_v = 1'b0;
    #1;
    n_cmp++;
    if (error !== 1'b1) begin
      n_bad++;
      $display("FAIL err_set: got %b expected 1", error);
    end
    mem_resp_v = 1'b1; resp_yumi = 2'b01;
    #1;
    n_cmp++;
    if (mem_resp_yumi !== 1'b0) begin
      n_bad++;
      $display("FAIL err_noack: got %b expected 0", mem_resp_yumi);
    end
    step();
    mem_resp_v = 1'b0; resp_yumi = 2'b00;
    repeat (3) step();
    n_cmp++;
    if (error !== 1'b1) begin
      n_bad++;
      $display("FAIL err_sticky: got %b expected 1", error);
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    req0_q.push_back(mk(1'b0, 80));
    req0_q.push_back(mk(1'b0, 81));
    issue_cycle(2'b01, 0);
    issue_cycle(2'b01, 1);
    rst_n = 1'b0;
    cmd_v = 2'b11; mem_resp_v = 1'b1; resp_yumi = 2'b00;
    #1;
    n_cmp++;
    if ({mem_cmd_v, resp_v, mem_resp_yumi, cmd_ready, error} !== 7'b0) begin
      n_bad++;
      $display("FAIL midrst_outputs: got %b expected 0000000",
               {mem_cmd_v, resp_v, mem_resp_yumi, cmd_ready, error});
    end
    @(posedge clk);
    @(negedge clk);
    cmd_v = 2'b00; mem_resp_v = 1'b0;
    req0_q.delete(); exp_cmd_q.delete(); mem_pend_q.delete(); exp_resp_q.delete();
    rst_n = 1'b1;
    step();
    req0_q.push_back(mk(1'b0, 96));
    req1_q.push_back(mk(1'b1, 97));
    issue_cycle(2'b01, 0);
    issue_cycle(2'b10, 1);
    issue_cycle(2'b00, 1);
    drain_resps(2);
    check_no_error("midrst");
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_full();
    test_backpressure();
    test_protocol_error();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bp_me_mem_cmd_arbiter.md
# bp_me_mem_cmd_arbiter

Two-requester arbiter that shares one BedRock memory port, such as the `bp_mem` model, between two cache engines, for example an I$ UCE and a D$ UCE.
- Commands are arbitrated round-robin and issued through a one-entry registered output buffer.
- Responses are steered back to the correct requester using an in-order FIFO of grant IDs, since the memory answers in command order.
- Message contents are opaque: the block routes without decoding any header field.

## Interface
- `msg_width_p`, default 256: width of one packed memory message (command or response).
- `outstanding_p`, default 4: maximum commands accepted but not yet answered; must be at least 1.

- `clk_i`, input, 1: clock; all state updates on the rising edge.
- `reset_i`, input, 1: reset, asynchronous and active-low.
- `cmd_i`, input, 2*msg_width_p: requester commands; requester r occupies bits [r*msg_width_p +: msg_width_p].
- `cmd_v_i`, input, 2: command valid, one bit per requester.
- `cmd_ready_o`, output, 2: command accepted this cycle when `cmd_v_i[r] & cmd_ready_o[r]`.
- `resp_o`, output, msg_width_p: response data, broadcast to both requesters.
- `resp_v_o`, output, 2: response valid for requester r.
- `resp_yumi_i`, input, 2: requester consumes the response.
- `mem_cmd_o`, output, msg_width_p: command to memory.
- `mem_cmd_v_o`, output, 1: memory command valid.
- `mem_cmd_ready_i`, input, 1: memory accepts the command.
- `mem_resp_i`, input, msg_width_p: response from memory.
- `mem_resp_v_i`, input, 1: memory response valid.
- `mem_resp_yumi_o`, output, 1: response consumed.
- `error_o`, output, 1: sticky flag for a protocol violation.

## Operation
- **Output buffer.** A one-entry register `obuf` with valid bit `obuf_v`. `mem_cmd_o`/`mem_cmd_v_o` are driven from it.
  - `obuf` can load when `~obuf_v | mem_cmd_ready_i`.
  - Dequeue and load in the same cycle is allowed.
- **Order FIFO.** Depth `outstanding_p`, 1-bit entries holding the requester ID, plus a count register.
  - Push on command acceptance.
  - Pop on `mem_resp_v_i & mem_resp_yumi_o`.
  - `full` = (count == `outstanding_p`).
- **Arbitration.** A round-robin pointer `last_r` records the last requester accepted.
  - If both requesters are valid, grant goes to the requester other than `last_r`.
  - If only one is valid, it wins.
  - `cmd_ready_o[r]` = grant[r] & obuf can load & ~full.
  - `full` is evaluated on registered count only. A same-cycle pop does not unblock a push.
  - `last_r` updates only on an actual acceptance. A ready offered without a handshake does not advance the pointer.
- **Response steering.** `head` is the FIFO head ID.
  - `resp_o` = `mem_resp_i`.
  - `resp_v_o[head]` = `mem_resp_v_i & ~empty`; the other bit is 0.
  - `mem_resp_yumi_o` = `resp_yumi_i[head] & ~empty`.
- **Error.** `error_o` sets on any of:
  - `mem_resp_v_i` while the FIFO is empty;
  - `resp_yumi_i[r]` without `resp_v_o[r]`.

  It stays set until reset. A response arriving with an empty FIFO is never acknowledged.
- **Reset (asynchronous, mid-operation).** All of the following clear immediately:
  - `obuf_v`, the FIFO pointers and count, `error_o`;
  - `last_r` is set to 1, so requester 0 wins the first tie.

  Any in-flight memory command or response is discarded. Memory must be reset together with this block.

## Timing
- **Reset values:**
  - `mem_cmd_v_o`=0, `resp_v_o`=0, `mem_resp_yumi_o`=0, `cmd_ready_o`=0 while reset is asserted, `error_o`=0.
  - `mem_cmd_o` is undefined but stable.
- **Command latency:** a command accepted at edge N is presented on `mem_cmd_o` with `mem_cmd_v_o`=1 in the cycle after edge N, and held stable until `mem_cmd_ready_i`.
- **Throughput:** one command per cycle while memory stays ready and the FIFO is not full.
- **Response path:** combinational, zero latency, no buffering.
- `cmd_ready_o` depends combinationally on `cmd_v_i` (through arbitration) and on `mem_cmd_ready_i`, but never on `resp_yumi_i`.
- **Count update:** count goes +1 on push, −1 on pop, unchanged on push+pop in the same cycle.

## Test plan
- **Single requester.** Requester 0 issues 3 commands back-to-back with memory always ready:
  - `mem_cmd_v_o` is high for 3 consecutive cycles starting the cycle after the first accept;
  - the 3 responses assert only `resp_v_o[0]`.
- **Tie and fairness.** Both requesters hold `cmd_v_i` continuously:
  - accept order is 0,1,0,1 starting from reset;
  - responses alternate `resp_v_o` = 01, 10, 01, 10.
- **Full.** `outstanding_p`=4 with no responses returned:
  - after 4 accepts `cmd_ready_o`=00;
  - a response plus yumi in one cycle keeps ready low that cycle; ready rises the next cycle.
- **Backpressure.** `mem_cmd_ready_i`=0 for 5 cycles with `obuf` full:
  - `mem_cmd_o` is held stable;
  - `cmd_ready_o`=00;
  - no FIFO push occurs.
- **Protocol error.** `mem_resp_v_i`=1 with an empty FIFO:
  - `error_o`=1 the next cycle;
  - `mem_resp_yumi_o`=0 and `resp_v_o`=00.
- **Mid-operation reset.** Assert `reset_i` low with 2 commands outstanding:
  - all valids drop immediately and the count is 0;
  - after release, requester 0 wins a tie.
